// File: rtl/divider8_seq.sv
// rtl/divider8_seq.sv - sequential unsigned 8-bit restoring divider, one quotient bit per cycle
module divider8_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q;
  logic [7:0] q_q;
  logic [7:0] d_q;
  logic [7:0] r_q;
  logic [2:0] cnt_q;
  logic       dz_q;

  logic [8:0] t_d;
  logic       borrow_d;
  logic [7:0] r_d;
  logic [7:0] q_d;

  // t_d is the 9-bit shifted partial remainder; whatever is kept after a step
  // is below the divisor, so the stored remainder always fits in 8 bits.
  always_comb begin
    t_d      = {r_q, q_q[7]};
    borrow_d = (t_d < {1'b0, d_q});
    r_d      = borrow_d ? t_d[7:0] : (t_d[7:0] - d_q);
    q_d      = {q_q[6:0], ~borrow_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= 8'd0;
      d_q     <= 8'd0;
      r_q     <= 8'd0;
      cnt_q   <= 3'd0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            q_q     <= dividend;
            d_q     <= divisor;
            r_q     <= 8'd0;
            cnt_q   <= 3'd0;
            dz_q    <= (divisor == 8'd0);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dz_q;

endmodule
